// File: rtl/i2c_slave_byte_ctrl_if.sv
// Bus and host-side signals of the byte-level I2C target controller.
// Handshake: rx_valid, tx_req and nack_rcvd are single-cycle strobes from the
// target. There is no back-pressure. The host must present tx_data from a
// tx_req strobe until the next detected SCL fall, and it samples rx_data and
// rx_first in the cycle rx_valid is high.
interface i2c_slave_byte_ctrl_if;
  logic       ena;
  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic       sda_oen;
  logic       ack_en;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       tx_req;
  logic       nack_rcvd;
  logic       busy;
  logic [2:0] dbg_state;

  modport slave (
    input  ena, scl_i, sda_i, ack_en, tx_data,
    output sda_o, sda_oen, rx_data, rx_valid, rx_first, tx_req, nack_rcvd,
           busy, dbg_state
  );

  modport master (
    output ena, scl_i, sda_i, ack_en, tx_data,
    input  sda_o, sda_oen, rx_data, rx_valid, rx_first, tx_req, nack_rcvd,
           busy, dbg_state
  );
endinterface

// File: rtl/i2c_slave_byte_ctrl.sv
// Byte-level I2C target: line synchronizer and glitch filter, START/STOP
// detection, 7-bit address match, byte receive to the host and byte transmit
// from the host. SDA is open drain (sda_o tied low) and SCL is never driven.
module i2c_slave_byte_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h21,
  parameter int         FILT_LEN   = 3
) (
  input  logic                  clk,
  input  logic                  nReset,
  i2c_slave_byte_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX       = 3'd3,
    RX_ACK   = 3'd4,
    TX       = 3'd5,
    TX_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  logic [1:0] scl_s_q, sda_s_q;
  logic       scl_f_q, sda_f_q;
  logic [3:0] scl_cnt_q, sda_cnt_q;

  state_t     state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       byte_done_q, byte_done_d;
  logic       rw_q, rw_d;
  logic       first_q, first_d;
  logic       busy_q, busy_d;
  logic       sda_oen_q, sda_oen_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       tx_req_q, tx_req_d;
  logic       nack_q, nack_d;

  // A filtered level flips on the cycle its FILT_LEN-th differing sample is
  // seen, so the edge strobes are combinational on that same cycle.
  logic scl_chg, sda_chg, scl_rise, scl_fall, start_det, stop_det;
  assign scl_chg   = (scl_s_q[1] != scl_f_q) && (scl_cnt_q == FILT_LAST);
  assign sda_chg   = (sda_s_q[1] != sda_f_q) && (sda_cnt_q == FILT_LAST);
  assign scl_rise  = scl_chg &  scl_s_q[1];
  assign scl_fall  = scl_chg & ~scl_s_q[1];
  // An SDA edge coinciding with an SCL edge is not treated as START/STOP.
  assign start_det = sda_chg & ~sda_s_q[1] & scl_f_q & ~scl_chg;
  assign stop_det  = sda_chg &  sda_s_q[1] & scl_f_q & ~scl_chg;

  // Two-stage synchronizers followed by a consecutive-sample glitch filter.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      scl_s_q   <= 2'b11;
      sda_s_q   <= 2'b11;
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
    end else begin
      scl_s_q <= {scl_s_q[0], bus.scl_i};
      sda_s_q <= {sda_s_q[0], bus.sda_i};
      if (scl_s_q[1] != scl_f_q) begin
        if (scl_chg) begin
          scl_f_q   <= scl_s_q[1];
          scl_cnt_q <= '0;
        end else begin
          scl_cnt_q <= scl_cnt_q + 4'd1;
        end
      end else begin
        scl_cnt_q <= '0;
      end
      if (sda_s_q[1] != sda_f_q) begin
        if (sda_chg) begin
          sda_f_q   <= sda_s_q[1];
          sda_cnt_q <= '0;
        end else begin
          sda_cnt_q <= sda_cnt_q + 4'd1;
        end
      end else begin
        sda_cnt_q <= '0;
      end
    end
  end

  // Protocol state, shift register and registered host/bus outputs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      byte_done_q <= 1'b0;
      rw_q        <= 1'b0;
      first_q     <= 1'b0;
      busy_q      <= 1'b0;
      sda_oen_q   <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_first_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      byte_done_q <= byte_done_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      busy_q      <= busy_d;
      sda_oen_q   <= sda_oen_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_first_q  <= rx_first_d;
      tx_req_q    <= tx_req_d;
      nack_q      <= nack_d;
    end
  end

  // Next-state logic: disable, then STOP, then START override the per-state
  // bit handling, so a repeated START is honoured from any state.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    byte_done_d = byte_done_q;
    rw_d        = rw_q;
    first_d     = first_q;
    busy_d      = busy_q;
    sda_oen_d   = sda_oen_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_first_d  = rx_first_q;
    tx_req_d    = 1'b0;
    nack_d      = 1'b0;

    if (!bus.ena) begin
      state_d     = IDLE;
      sda_oen_d   = 1'b1;
      busy_d      = 1'b0;
      byte_done_d = 1'b0;
    end else if (stop_det) begin
      state_d     = IDLE;
      sda_oen_d   = 1'b1;
      busy_d      = 1'b0;
      byte_done_d = 1'b0;
    end else if (start_det) begin
      state_d     = ADDR;
      bitcnt_d    = '0;
      byte_done_d = 1'b0;
      sda_oen_d   = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shreg_d  = {shreg_q[6:0], sda_f_q};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if (shreg_q[7:1] == SLAVE_ADDR) begin
              busy_d    = 1'b1;
              rw_d      = shreg_q[0];
              sda_oen_d = 1'b0;
              state_d   = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise && rw_q) begin
            tx_req_d = 1'b1;
          end else if (scl_fall) begin
            bitcnt_d = '0;
            if (rw_q) begin
              shreg_d   = bus.tx_data;
              sda_oen_d = bus.tx_data[7];
              state_d   = TX;
            end else begin
              sda_oen_d = 1'b1;
              first_d   = 1'b1;
              state_d   = RX;
            end
          end
        end
        RX: begin
          if (scl_rise) begin
            shreg_d  = {shreg_q[6:0], sda_f_q};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              rx_data_d   = {shreg_q[6:0], sda_f_q};
              rx_valid_d  = 1'b1;
              rx_first_d  = first_q;
              first_d     = 1'b0;
              byte_done_d = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            sda_oen_d   = ~bus.ack_en;
            state_d     = RX_ACK;
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_oen_d = 1'b1;
            bitcnt_d  = '0;
            state_d   = RX;
          end
        end
        TX: begin
          if (scl_fall) begin
            if (bitcnt_q == 3'd7) begin
              sda_oen_d = 1'b1;
              state_d   = TX_ACK;
            end else begin
              bitcnt_d  = bitcnt_q + 3'd1;
              shreg_d   = {shreg_q[6:0], 1'b0};
              sda_oen_d = shreg_q[6];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (!sda_f_q) begin
              tx_req_d = 1'b1;
            end else begin
              nack_d  = 1'b1;
              state_d = IGNORE;
            end
          end else if (scl_fall) begin
            shreg_d   = bus.tx_data;
            sda_oen_d = bus.tx_data[7];
            bitcnt_d  = '0;
            state_d   = TX;
          end
        end
        IGNORE:  sda_oen_d = 1'b1;
        default: state_d   = IDLE;
      endcase
    end
  end

  assign bus.sda_o     = 1'b0;
  assign bus.sda_oen   = sda_oen_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_first  = rx_first_q;
  assign bus.tx_req    = tx_req_q;
  assign bus.nack_rcvd = nack_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Bench for i2c_slave_byte_ctrl: a bus master model drives SCL/SDA through an
// open-drain wired-AND, a host responder supplies tx_data on tx_req, and a
// monitor checks every rx_valid / tx_req / nack_rcvd strobe against exp_q.
module tb_i2c_slave_byte_ctrl;
  localparam int W       = 11;   // {kind[1:0], first, data[7:0]}
  localparam int QUARTER = 10;
  localparam int HALF    = 20;
  localparam logic [1:0] K_RXV = 2'd1, K_TXR = 2'd2, K_NCK = 2'd3;
  localparam logic [2:0] S_IDLE = 3'd0, S_IGNORE = 3'd7;

  logic clk = 1'b0;
  logic nReset;
  logic scl_m, sda_m;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   drive_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   host_q[$];

  i2c_slave_byte_ctrl_if bus();

  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & (bus.sda_oen | bus.sda_o);

  i2c_slave_byte_ctrl #(.SLAVE_ADDR(7'h21), .FILT_LEN(3)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name, input logic [W-1:0] got);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected event 0x%0h, expected none", name, got);
    end else begin
      e = exp_q.pop_front();
      check(name, {21'd0, got}, {21'd0, e});
    end
  endtask

  // monitor: one pop per strobe, sampled on the falling clock edge
  initial forever begin
    @(negedge clk);
    if (bus.rx_valid)  sb_pop("rx_valid", {K_RXV, bus.rx_first, bus.rx_data});
    if (bus.tx_req)    sb_pop("tx_req",   {K_TXR, 1'b0, 8'h00});
    if (bus.nack_rcvd) sb_pop("nack",     {K_NCK, 1'b0, 8'h00});
    if (!bus.sda_oen)  drive_cnt++;
  end

  // host responder: present next transmit byte after each tx_req
  initial forever begin
    @(negedge clk);
    if (bus.tx_req && host_q.size() != 0) bus.tx_data = host_q.pop_front();
  end

  // ---------------- bus master driver ----------------
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_start;
    sda_m = 1'b1; clks(QUARTER);
    scl_m = 1'b1; clks(HALF);
    sda_m = 1'b0; clks(HALF);
    scl_m = 1'b0; clks(QUARTER);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; clks(QUARTER);
    scl_m = 1'b1; clks(HALF);
    sda_m = 1'b1; clks(HALF);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    sda_m = b;
    if (glitch) begin
      clks(4);
      scl_m = 1'b1; clks(1);
      scl_m = 1'b0; clks(QUARTER - 5);
    end else begin
      clks(QUARTER);
    end
    scl_m = 1'b1; clks(HALF);
    scl_m = 1'b0; clks(QUARTER);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; clks(QUARTER);
    scl_m = 1'b1; clks(HALF / 2);
    b = bus.sda_i;
    clks(HALF / 2);
    scl_m = 1'b0; clks(QUARTER);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack, 1'b0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic       ack;
    logic [7:0] d;
    nReset = 1'b0;
    scl_m = 1'b1; sda_m = 1'b1;
    bus.ena = 1'b1; bus.ack_en = 1'b1; bus.tx_data = 8'h00;
    clks(5);
    @(negedge clk);
    check("reset sda_oen", {31'd0, bus.sda_oen}, 32'd1);
    nReset = 1'b1;
    clks(10);
    @(negedge clk);
    check("reset sda_o",    {31'd0, bus.sda_o},    32'd0);
    check("reset busy",     {31'd0, bus.busy},     32'd0);
    check("reset rx_data",  {24'd0, bus.rx_data},  32'h00);
    check("reset rx_first", {31'd0, bus.rx_first}, 32'd0);
    check("reset state",    {29'd0, bus.dbg_state}, {29'd0, S_IDLE});

    // write 0x42: 0x12, 0x80 with ACKs
    exp_q.push_back({K_RXV, 1'b1, 8'h12});
    exp_q.push_back({K_RXV, 1'b0, 8'h80});
    bus_start();
    write_byte(8'h42, -1, ack); check("wr addr ack", {31'd0, ack}, 32'd0);
    check("wr busy", {31'd0, bus.busy}, 32'd1);
    write_byte(8'h12, -1, ack); check("wr d0 ack", {31'd0, ack}, 32'd0);
    write_byte(8'h80, -1, ack); check("wr d1 ack", {31'd0, ack}, 32'd0);
    bus_stop();
    clks(10);
    check("wr busy after stop", {31'd0, bus.busy}, 32'd0);
    check("wr rx_data", {24'd0, bus.rx_data}, 32'h80);

    // non-matching address: target stays off the bus
    drive_cnt = 0;
    bus_start();
    write_byte(8'h60, -1, ack); check("miss addr nack", {31'd0, ack}, 32'd1);
    write_byte(8'h55, -1, ack); check("miss data nack", {31'd0, ack}, 32'd1);
    check("miss busy", {31'd0, bus.busy}, 32'd0);
    check("miss state", {29'd0, bus.dbg_state}, {29'd0, S_IGNORE});
    bus_stop();
    clks(10);
    check("miss sda never driven", drive_cnt, 32'd0);
    check("miss state after stop", {29'd0, bus.dbg_state}, {29'd0, S_IDLE});

    // read 0x43: 0xA5 (ACK), 0x3C (NACK)
    host_q.push_back(8'hA5);
    host_q.push_back(8'h3C);
    exp_q.push_back({K_TXR, 1'b0, 8'h00});
    exp_q.push_back({K_TXR, 1'b0, 8'h00});
    exp_q.push_back({K_NCK, 1'b0, 8'h00});
    bus_start();
    write_byte(8'h43, -1, ack); check("rd addr ack", {31'd0, ack}, 32'd0);
    read_byte(d, 1'b0); check("rd byte0", {24'd0, d}, 32'hA5);
    read_byte(d, 1'b1); check("rd byte1", {24'd0, d}, 32'h3C);
    bus_stop();
    clks(10);
    check("rd busy after stop", {31'd0, bus.busy}, 32'd0);

    // write 0x0A, repeated START, read one byte
    exp_q.push_back({K_RXV, 1'b1, 8'h0A});
    exp_q.push_back({K_TXR, 1'b0, 8'h00});
    exp_q.push_back({K_NCK, 1'b0, 8'h00});
    host_q.push_back(8'h5A);
    bus_start();
    write_byte(8'h42, -1, ack); check("rs wr addr ack", {31'd0, ack}, 32'd0);
    write_byte(8'h0A, -1, ack); check("rs wr data ack", {31'd0, ack}, 32'd0);
    bus_start();
    write_byte(8'h43, -1, ack); check("rs rd addr ack", {31'd0, ack}, 32'd0);
    read_byte(d, 1'b1); check("rs rd byte", {24'd0, d}, 32'h5A);
    check("rs rx_data retained", {24'd0, bus.rx_data}, 32'h0A);
    bus_stop();
    clks(10);

    // one-clock SCL glitch during the address
    exp_q.push_back({K_RXV, 1'b1, 8'h77});
    bus_start();
    write_byte(8'h42, 2, ack); check("glitch addr ack", {31'd0, ack}, 32'd0);
    write_byte(8'h77, -1, ack); check("glitch data ack", {31'd0, ack}, 32'd0);
    bus_stop();
    clks(10);

    // reset while the target drives SDA low mid-TX
    host_q.push_back(8'h3C);
    exp_q.push_back({K_TXR, 1'b0, 8'h00});
    bus_start();
    write_byte(8'h43, -1, ack); check("rst addr ack", {31'd0, ack}, 32'd0);
    check("rst sda driven", {31'd0, bus.sda_oen}, 32'd0);
    @(negedge clk);
    nReset = 1'b0;
    #1;
    check("rst sda_oen async", {31'd0, bus.sda_oen}, 32'd1);
    clks(3);
    nReset = 1'b1;
    clks(3);
    @(negedge clk);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst state", {29'd0, bus.dbg_state}, {29'd0, S_IDLE});
    bus_stop();
    clks(20);

    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_slave_byte_ctrl.md
# i2c_slave_byte_ctrl

Byte-level I2C target (slave) controller: the responder end of the bus driven by the team's I2C master cores. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, and ACKs it. It then receives bytes to the host or transmits host-supplied bytes. It sits behind the open-drain pad logic and is used to emulate camera-sensor SCCB/I2C register targets (e.g. OV7670 at 0x21) in board bring-up and benches.

## Interface
- SLAVE_ADDR, 7'h21: 7-bit address this target answers to.
- FILT_LEN, 3: glitch-filter length; a synchronized line level is accepted after FILT_LEN consecutive equal samples (1..15).
- clk  input  1  system clock; all logic on posedge.
- nReset  input  1  asynchronous, active-low reset.
- ena  input  1  core enable; 0 forces IDLE, SDA released, busy=0.
- scl_i  input  1  SCL pad input.
- sda_i  input  1  SDA pad input.
- sda_o  output  1  SDA output value; constant 0 (open drain).
- sda_oen  output  1  SDA output enable, active-low; 1 = released.
- ack_en  input  1  1 = ACK received data bytes, 0 = NACK them (the address is always ACKed).
- tx_data  input  8  byte to transmit on reads.
- rx_data  output  8  last received data byte.
- rx_valid  output  1  1-cycle pulse: rx_data updated.
- rx_first  output  1  valid with rx_valid: byte is the first after the address.
- tx_req  output  1  1-cycle pulse: host must present the next tx_data.
- nack_rcvd  output  1  1-cycle pulse: master NACKed a transmitted byte.
- busy  output  1  high from an address-matched START until STOP.

## Operation
- Line conditioning: 2-FF synchronizer per line, then the FILT_LEN filter. Filtered edges give scl_rise, scl_fall, start (SDA fall while SCL high), and stop (SDA rise while SCL high). If SCL and SDA change in the same filtered cycle, only the SCL edge is taken.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE. A 3-bit bit counter and an 8-bit shift register support them.
- start, any state: -> ADDR, counter=0, SDA released (repeated START supported).
- stop, any state: -> IDLE, SDA released, busy=0.
- ADDR: shift sda on scl_rise. At the scl_fall after the 8th bit, on a match of bits[7:1]==SLAVE_ADDR: busy=1, latch R/W, drive SDA low -> ADDR_ACK. On a mismatch -> IGNORE.
- ADDR_ACK: tx_req pulses at the scl_rise of the ACK bit if R/W=1. At the scl_fall ending ACK: if W -> RX with SDA released. If R -> load tx_data, drive bit 7 -> TX.
- RX: sample on scl_rise. At the 8th rise: rx_data<=byte, pulse rx_valid, and set rx_first if this is the first byte since the address. At the next scl_fall, drive SDA low if ack_en, else release -> RX_ACK.
- RX_ACK: at scl_fall, release -> RX, counter=0.
- TX: at each scl_fall, present the next bit (sda_oen = bit). At the scl_fall after bit 0, release -> TX_ACK.
- TX_ACK: sample at scl_rise. On sda=0, pulse tx_req; at scl_fall, load tx_data -> TX. On sda=1, pulse nack_rcvd -> IGNORE.
- IGNORE: SDA released; wait for start/stop.

## Timing
- Reset values: sda_oen=1, sda_o=0, rx_data=0x00, rx_valid=0, rx_first=0, tx_req=0, nack_rcvd=0, busy=0, state IDLE. sda_oen=1 asynchronously while nReset=0.
- Edge detect latency: 2+FILT_LEN clk from the pad transition to the internal edge. SDA drive changes 1 clk after the detected scl_fall, giving hold time ≥ (3+FILT_LEN)/f_clk.
- tx_data must be stable from the tx_req pulse through the following detected scl_fall, which is at least one SCL high phase.
- rx_valid is registered 1 clk after the 8th detected scl_rise.
- No clock stretching; SCL is never driven.
- ena falling mid-transfer: SDA released next clk, state IDLE, no pulses.

## Test plan
- Write 0x42, 0x12, 0x80, STOP with ack_en=1 -> ACK low on all 3 ACK bits. rx_valid twice: 0x12 (rx_first=1), then 0x80 (rx_first=0). busy falls after STOP.
- Address 0x60 write -> SDA never driven, busy=0, no rx_valid, IGNORE until STOP.
- Read 0x43, host tx_data=0xA5 then 0x3C, master ACK then NACK -> bus bits 10100101, 00111100. tx_req pulses twice. nack_rcvd pulses once after the second byte.
- Write 0x42, 0x0A, repeated START, 0x43, read -> re-enters ADDR, ACKs, tx_req after the address. rx_data=0x0A retained.
- 1-clk glitch on SCL (FILT_LEN=3) during the address -> no extra bit shifted; address still matches.
- nReset low mid-TX with SDA driven low -> sda_oen=1 immediately; after release, state IDLE, busy=0.
